// File: rtl/nrisc_defs_pkg.sv
// Shared nRISC definitions: default datapath widths and the load/store FSM encoding.
package nrisc_defs;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/mdd_addr_gen.sv
// Effective address adder: base + immediate, wrapping modulo 2^ADDR_W.
module mdd_addr_gen
  import nrisc_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] addr
);

  // Same-width sum so the carry out falls off the top.
  assign addr = base + imm;

endmodule

// File: rtl/mdd_access_ctrl.sv
// Load/store initiator for the MDD data memory: one outstanding request, Moore outputs.
module mdd_access_ctrl
  import nrisc_defs::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_imm,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_store,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data
);

  logic [1:0]        state;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] eff_addr;

  mdd_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base (req_base),
    .imm  (req_imm),
    .addr (eff_addr)
  );

  // Every output is its own flop, updated alongside the state, so nothing
  // combinational reaches the ports from req_* or resp_ready.
  // NOTE: non-blocking assignments throughout; every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      lat_cnt        <= 4'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_is_store  <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            mem_address <= eff_addr;
            if (req_we) begin
              state          <= ST_WRITE;
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state    <= ST_READ;
              mem_read <= 1'b1;
              lat_cnt  <= 4'(READ_LATENCY - 1);
            end
          end
        end
        ST_WRITE: begin
          state          <= ST_RESP;
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
          resp_is_store  <= 1'b1;
          resp_rdata     <= '0;
        end
        ST_READ: begin
          if (lat_cnt == 4'd0) begin
            state         <= ST_RESP;
            mem_read      <= 1'b0;
            resp_valid    <= 1'b1;
            resp_is_store <= 1'b0;
            resp_rdata    <= mem_data;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
